// File: rtl/elevador_escalonador_if.sv
// Elevator scheduler bus: floor calls and sensors in, car commands out.
interface elevador_escalonador_if #(
  parameter int N_FLOORS = 4,
  parameter int FW       = $clog2(N_FLOORS)
);
  logic [N_FLOORS-1:0] call_req;
  logic                door_block;
  logic                emerg;
  logic [FW-1:0]       floor;
  logic                motor_up;
  logic                motor_down;
  logic                door_open;
  logic                dir_up;
  logic [N_FLOORS-1:0] pending;
  logic                erro;

  modport master (
    output call_req,
    output door_block,
    output emerg,
    input  floor,
    input  motor_up,
    input  motor_down,
    input  door_open,
    input  dir_up,
    input  pending,
    input  erro
  );

  modport slave (
    input  call_req,
    input  door_block,
    input  emerg,
    output floor,
    output motor_up,
    output motor_down,
    output door_open,
    output dir_up,
    output pending,
    output erro
  );
endinterface

// File: rtl/elevador_escalonador.sv
// SCAN call scheduler for one elevator car: latches calls, drives
// motor and door commands, tracks the floor and a sticky fault.
module elevador_escalonador #(
  parameter int N_FLOORS   = 4,
  parameter int MOVE_TICKS = 8,
  parameter int DOOR_TICKS = 6,
  parameter int BLOCK_MAX  = 64,
  parameter int FW         = $clog2(N_FLOORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elevador_escalonador_if.slave bus
);

  localparam int TMAX = (MOVE_TICKS > DOOR_TICKS) ?
                        MOVE_TICKS : DOOR_TICKS;
  localparam int CW = $clog2(TMAX);
  localparam int BW = $clog2(BLOCK_MAX);

  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLOCK_MAX - 1);
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR,
    S_FAULT
  } state_t;

  state_t              state_q;
  logic [FW-1:0]       floor_q;
  logic [N_FLOORS-1:0] pending_q;
  logic                dir_up_q;
  logic                motor_up_q;
  logic                motor_down_q;
  logic                door_open_q;
  logic                erro_q;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       blk_q;

  logic [N_FLOORS-1:0] pend_set_d;
  logic [FW-1:0]       floor_up_d;
  logic [FW-1:0]       floor_dn_d;
  logic [N_FLOORS-1:0] here_mask;
  logic [N_FLOORS-1:0] up_mask;
  logic [N_FLOORS-1:0] dn_mask;
  logic                call_here;
  logic                call_above;
  logic                call_below;
  logic                arr_up_here;
  logic                arr_up_ahead;
  logic                arr_dn_here;
  logic                arr_dn_ahead;

  function automatic logic any_above(
    input logic [N_FLOORS-1:0] p,
    input logic [FW-1:0]       f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (p[i] && (i > int'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(
    input logic [N_FLOORS-1:0] p,
    input logic [FW-1:0]       f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (p[i] && (i < int'(f))) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    pend_set_d   = pending_q | bus.call_req;
    floor_up_d   = floor_q + FW'(1);
    floor_dn_d   = floor_q - FW'(1);
    here_mask    = ONE << floor_q;
    up_mask      = ONE << floor_up_d;
    dn_mask      = ONE << floor_dn_d;
    call_here    = |(pending_q & here_mask);
    call_above   = any_above(pending_q, floor_q);
    call_below   = any_below(pending_q, floor_q);
    arr_up_here  = |(pending_q & up_mask);
    arr_up_ahead = any_above(pending_q, floor_up_d);
    arr_dn_here  = |(pending_q & dn_mask);
    arr_dn_ahead = any_below(pending_q, floor_dn_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      floor_q      <= '0;
      pending_q    <= '0;
      dir_up_q     <= 1'b1;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
      erro_q       <= 1'b0;
      cnt_q        <= '0;
      blk_q        <= '0;
    end else if (state_q != S_FAULT) begin
      pending_q <= pend_set_d;
      if (bus.emerg) begin
        // emergency wins over any arrival or door event this cycle
        state_q      <= S_FAULT;
        motor_up_q   <= 1'b0;
        motor_down_q <= 1'b0;
        erro_q       <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
            if (call_here) begin
              state_q     <= S_DOOR;
              door_open_q <= 1'b1;
              blk_q       <= '0;
              pending_q   <= pend_set_d & ~here_mask;
            end else if (call_above && (dir_up_q || !call_below)) begin
              state_q    <= S_MOVE_UP;
              dir_up_q   <= 1'b1;
              motor_up_q <= 1'b1;
            end else if (call_below) begin
              state_q      <= S_MOVE_DOWN;
              dir_up_q     <= 1'b0;
              motor_down_q <= 1'b1;
            end
          end
          S_MOVE_UP: begin
            if (cnt_q == MOVE_LAST) begin
              cnt_q   <= '0;
              floor_q <= floor_up_d;
              if (arr_up_here) begin
                state_q     <= S_DOOR;
                motor_up_q  <= 1'b0;
                door_open_q <= 1'b1;
                blk_q       <= '0;
                pending_q   <= pend_set_d & ~up_mask;
              end else if (!arr_up_ahead) begin
                state_q    <= S_IDLE;
                motor_up_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_MOVE_DOWN: begin
            if (cnt_q == MOVE_LAST) begin
              cnt_q   <= '0;
              floor_q <= floor_dn_d;
              if (arr_dn_here) begin
                state_q      <= S_DOOR;
                motor_down_q <= 1'b0;
                door_open_q  <= 1'b1;
                blk_q        <= '0;
                pending_q    <= pend_set_d & ~dn_mask;
              end else if (!arr_dn_ahead) begin
                state_q      <= S_IDLE;
                motor_down_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_DOOR: begin
            // calls to this floor are absorbed while the door is open
            pending_q <= pend_set_d & ~here_mask;
            if (bus.door_block) begin
              cnt_q <= '0;
              if (blk_q == BLK_LAST) begin
                state_q <= S_FAULT;
                erro_q  <= 1'b1;
              end else begin
                blk_q <= blk_q + BW'(1);
              end
            end else begin
              blk_q <= '0;
              if (cnt_q == DOOR_LAST) begin
                state_q     <= S_IDLE;
                door_open_q <= 1'b0;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_FAULT: begin
          end
        endcase
      end
    end
  end

  assign bus.floor      = floor_q;
  assign bus.motor_up   = motor_up_q;
  assign bus.motor_down = motor_down_q;
  assign bus.door_open  = door_open_q;
  assign bus.dir_up     = dir_up_q;
  assign bus.pending    = pending_q;
  assign bus.erro       = erro_q;

endmodule

// File: tb/tb_elevador_escalonador.sv
// Bench for elevador_escalonador: directed scenarios plus random calls
// against a countdown-based car model.
module tb_elevador_escalonador;

  localparam int NF = 4;
  localparam int MT = 4;
  localparam int DT = 3;
  localparam int BM = 8;
  localparam int AGE_MAX = 2 * NF * (MT + DT) + 4;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DOWN  = 2;
  localparam int M_DOOR  = 3;
  localparam int M_FAULT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  elevador_escalonador_if #(.N_FLOORS(NF)) bus ();

  elevador_escalonador #(
    .N_FLOORS  (NF),
    .MOVE_TICKS(MT),
    .DOOR_TICKS(DT),
    .BLOCK_MAX (BM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          m_floor;
  int          m_mode;
  int          m_left;
  int          m_run;
  bit          m_dir;
  bit          m_door;
  bit [NF-1:0] m_pend;

  bit age_on = 1'b0;
  int age [NF];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit calls_above(input bit [NF-1:0] p, input int f);
    for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_below(input bit [NF-1:0] p, input int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_floor = 0;
    m_mode  = M_IDLE;
    m_left  = 0;
    m_run   = 0;
    m_dir   = 1'b1;
    m_door  = 1'b0;
    m_pend  = '0;
  endfunction

  function automatic void model_step(input bit [NF-1:0] cr,
                                     input bit blk, input bit em);
    bit [NF-1:0] nxt;
    bit going_up;
    if (m_mode == M_FAULT) return;
    nxt = m_pend | cr;
    if (em) begin
      m_pend = nxt;
      m_mode = M_FAULT;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_floor]) begin
          m_mode = M_DOOR; m_door = 1'b1; m_left = DT; m_run = 0;
          nxt[m_floor] = 1'b0;
        end else if (calls_above(m_pend, m_floor) &&
                     (m_dir || !calls_below(m_pend, m_floor))) begin
          m_dir = 1'b1; m_mode = M_UP; m_left = MT;
        end else if (calls_below(m_pend, m_floor)) begin
          m_dir = 1'b0; m_mode = M_DOWN; m_left = MT;
        end
      end
      M_UP, M_DOWN: begin
        going_up = (m_mode == M_UP);
        m_left--;
        if (m_left == 0) begin
          m_floor = going_up ? m_floor + 1 : m_floor - 1;
          if (m_pend[m_floor]) begin
            m_mode = M_DOOR; m_door = 1'b1; m_left = DT; m_run = 0;
            nxt[m_floor] = 1'b0;
          end else if (going_up ? calls_above(m_pend, m_floor)
                                : calls_below(m_pend, m_floor)) begin
            m_left = MT;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      M_DOOR: begin
        nxt[m_floor] = 1'b0;
        if (blk) begin
          m_run++;
          m_left = DT;
          if (m_run == BM) m_mode = M_FAULT;
        end else begin
          m_run = 0;
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            m_door = 1'b0;
          end
        end
      end
      default: ;
    endcase
    m_pend = nxt;
  endfunction

  task automatic compare_all();
    chk("floor", 32'(bus.floor), m_floor);
    chk("motor_up", 32'(bus.motor_up), 32'(m_mode == M_UP));
    chk("motor_down", 32'(bus.motor_down), 32'(m_mode == M_DOWN));
    chk("door_open", 32'(bus.door_open), 32'(m_door));
    chk("dir_up", 32'(bus.dir_up), 32'(m_dir));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("erro", 32'(bus.erro), 32'(m_mode == M_FAULT));
    chk("inv_updown", 32'(bus.motor_up & bus.motor_down), 0);
    chk("inv_doormove",
        32'(bus.door_open & (bus.motor_up | bus.motor_down)), 0);
  endtask

  task automatic tick();
    bit [NF-1:0] cr;
    bit b;
    bit e;
    cr = bus.call_req;
    b  = bus.door_block;
    e  = bus.emerg;
    @(posedge clk);
    #1;
    model_step(cr, b, e);
    compare_all();
    if (age_on) begin
      for (int i = 0; i < NF; i++) begin
        if (bus.pending[i] === 1'b1) begin
          age[i]++;
          chk("pend_age", 32'(age[i] > AGE_MAX), 0);
        end else begin
          age[i] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    bus.call_req   = '0;
    bus.door_block = 1'b0;
    bus.emerg      = 1'b0;
    rst_n = 1'b0;
    #4;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_door(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.door_open === 1'b1) break;
    end
    chk(tag, 32'(bus.door_open), 1);
  endtask

  initial begin
    bus.call_req   = '0;
    bus.door_block = 1'b0;
    bus.emerg      = 1'b0;
    #3;
    do_reset();

    // ground call at ground floor: door only
    bus.call_req = 4'b0001; tick();
    chk("t3_pend", 32'(bus.pending), 32'h1);
    bus.call_req = '0; tick();
    chk("t3_door", 32'(bus.door_open), 1);
    chk("t3_motor", 32'({bus.motor_up, bus.motor_down}), 0);
    repeat (DT) tick();
    chk("t3_close", 32'(bus.door_open), 0);

    bus.call_req = 4'b0100; tick();
    bus.call_req = '0;
    wait_door("go2_wait", 40);
    chk("go2_floor", 32'(bus.floor), 2);
    repeat (DT) tick();

    // floor 2 going up, calls at 3 and 0
    bus.call_req = 4'b1001; tick();
    bus.call_req = '0;
    wait_door("t2_wait3", 40);
    chk("t2_floor3", 32'(bus.floor), 3);
    chk("t2_pend0", 32'(bus.pending), 32'h1);
    chk("t2_dirup", 32'(bus.dir_up), 1);
    repeat (DT) tick();
    chk("t2_close3", 32'(bus.door_open), 0);
    wait_door("t2_wait0", 60);
    chk("t2_floor0", 32'(bus.floor), 0);
    chk("t2_dirdn", 32'(bus.dir_up), 0);
    chk("t2_pend_none", 32'(bus.pending), 0);
    repeat (DT) tick();

    // ground to top
    do_reset();
    bus.call_req = 4'b1000; tick();
    bus.call_req = '0;
    chk("t1_pend", 32'(bus.pending), 32'h8);
    chk("t1_mu_wait", 32'(bus.motor_up), 0);
    tick();
    chk("t1_mu", 32'(bus.motor_up), 1);
    for (int f = 1; f <= 3; f++) begin
      repeat (MT) tick();
      chk("t1_floor", 32'(bus.floor), f);
    end
    chk("t1_door", 32'(bus.door_open), 1);
    chk("t1_pend_clr", 32'(bus.pending), 0);
    chk("t1_mu_off", 32'(bus.motor_up), 0);
    repeat (DT - 1) tick();
    chk("t1_door_hold", 32'(bus.door_open), 1);
    tick();
    chk("t1_door_close", 32'(bus.door_open), 0);

    // obstruction pulse, then timeout
    bus.call_req = 4'b1000; tick();
    bus.call_req = '0; tick();
    chk("t4_open", 32'(bus.door_open), 1);
    tick();
    bus.door_block = 1'b1; tick();
    bus.door_block = 1'b0;
    repeat (DT - 1) tick();
    chk("t4_held", 32'(bus.door_open), 1);
    tick();
    chk("t4_closed", 32'(bus.door_open), 0);
    bus.call_req = 4'b1000; tick();
    bus.call_req = '0; tick();
    bus.door_block = 1'b1;
    repeat (BM - 1) tick();
    chk("t4_erro_pre", 32'(bus.erro), 0);
    tick();
    chk("t4_erro", 32'(bus.erro), 1);
    chk("t4_motors", 32'({bus.motor_up, bus.motor_down}), 0);
    chk("t4_door_kept", 32'(bus.door_open), 1);
    bus.door_block = 1'b0;
    repeat (3) tick();
    chk("t4_sticky", 32'(bus.erro), 1);

    // emergency between floors
    do_reset();
    bus.call_req = 4'b1000; tick();
    bus.call_req = '0; tick();
    repeat (MT + 2) tick();
    chk("t5_moving", 32'(bus.motor_up), 1);
    chk("t5_floor1", 32'(bus.floor), 1);
    bus.emerg = 1'b1; tick();
    bus.emerg = 1'b0;
    chk("t5_mu_off", 32'(bus.motor_up), 0);
    chk("t5_erro", 32'(bus.erro), 1);
    chk("t5_frozen", 32'(bus.floor), 1);
    bus.call_req = 4'b0101;
    repeat (5) tick();
    bus.call_req = '0;
    chk("t5_ignored", 32'(bus.pending), 32'h8);
    chk("t5_still", 32'(bus.floor), 1);
    do_reset();

    // random calls, no obstruction
    for (int i = 0; i < NF; i++) age[i] = 0;
    age_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      bus.call_req = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      tick();
    end
    age_on = 1'b0;

    // random calls with sporadic obstruction
    for (int c = 0; c < 300; c++) begin
      bus.call_req = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      bus.door_block = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.call_req = '0;
    bus.door_block = 1'b0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
